// File: rtl/spi_frame_slave.sv
// SPI frame slave front end: synchronises the SPI pins into clk, collects
// fixed-width frames into a small register file, issues a start pulse after
// the last register of a command and returns a held core result on MISO.
module spi_frame_slave #(
  parameter int FRAME_W     = 64,
  parameter int NUM_REGS    = 3,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  localparam int PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         mosi,
  output logic                         miso,
  input  logic                         core_busy,
  input  logic                         result_valid,
  input  logic [FRAME_W-1:0]           result_data,
  output logic [NUM_REGS*FRAME_W-1:0]  regs_out,
  output logic                         start,
  output logic [PTR_W-1:0]             wr_ptr,
  output logic                         result_ready,
  output logic                         frame_err,
  output logic                         drop
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                   state_reg, state_next;
  logic [SYNC_STAGES-1:0]   sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic                     sclk_prev_reg, cs_prev_reg;
  logic [FRAME_W-1:0]       rx_shift_reg, tx_shift_reg, hold_reg;
  logic [CNT_W-1:0]         bit_cnt_reg;
  logic                     rb_frame_reg, result_ready_reg;
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic                     start_reg, frame_err_reg, drop_reg;
  logic                     sclk_s, cs_s, mosi_s;
  logic                     sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                     sample_edge, change_edge;
  logic                     commit_err, commit_rb, commit_drop, commit_wr;

  // Pin synchronisers; cs_n resets low so a frame already in progress at
  // reset release is never mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
      cs_prev_reg   <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s        = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_reg;
  assign sclk_fall   = ~sclk_s & sclk_prev_reg;
  assign cs_rise     = cs_s & ~cs_prev_reg;
  assign cs_fall     = ~cs_s & cs_prev_reg;
  assign sample_edge = (CPHA == 0) ? sclk_rise : sclk_fall;
  assign change_edge = (CPHA == 0) ? sclk_fall : sclk_rise;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic and classification of the frame being committed.
  always_comb begin
    state_next  = state_reg;
    commit_err  = 1'b0;
    commit_rb   = 1'b0;
    commit_drop = 1'b0;
    commit_wr   = 1'b0;
    case (state_reg)
      IDLE:   if (cs_fall) state_next = SHIFT;
      SHIFT:  if (cs_rise) state_next = COMMIT;
      COMMIT: begin
        state_next = IDLE;
        if (bit_cnt_reg != CNT_FULL) commit_err  = 1'b1;
        else if (rb_frame_reg)       commit_rb   = 1'b1;
        else if (core_busy)          commit_drop = 1'b1;
        else                         commit_wr   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers and bit counter. The transmit register only shifts once
  // a bit has been sampled, so with CPHA=1 the leading change edge keeps the
  // MSB on the line instead of discarding it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
      rb_frame_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (cs_fall) begin
        bit_cnt_reg  <= '0;
        rb_frame_reg <= result_ready_reg;
        tx_shift_reg <= result_ready_reg ? hold_reg : '0;
      end
    end else if (state_reg == SHIFT) begin
      if (sample_edge) begin
        rx_shift_reg <= {rx_shift_reg[FRAME_W-2:0], mosi_s};
        if (bit_cnt_reg != CNT_SAT) bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      end
      if (change_edge && bit_cnt_reg != '0)
        tx_shift_reg <= {tx_shift_reg[FRAME_W-2:0], 1'b0};
    end
  end

  // Write pointer and one-clk status pulses issued from the commit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      start_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      start_reg     <= commit_wr && (wr_ptr_reg == PTR_LAST);
      frame_err_reg <= commit_err;
      drop_reg      <= commit_drop;
      if (commit_wr) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
  end

  // Result hold register; a new result wins over the readback clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg         <= '0;
      result_ready_reg <= 1'b0;
    end else if (result_valid) begin
      hold_reg         <= result_data;
      result_ready_reg <= 1'b1;
    end else if (commit_rb) begin
      result_ready_reg <= 1'b0;
    end
  end

  // Register file: one word per command frame slot.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [FRAME_W-1:0] value_reg;
    // Capture the received frame when this slot is the write target.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                          value_reg <= '0;
      else if (commit_wr && wr_ptr_reg == PTR_W'(gi))    value_reg <= rx_shift_reg;
    end
    assign regs_out[gi*FRAME_W +: FRAME_W] = value_reg;
  end

  assign miso         = (state_reg == SHIFT) & ~cs_n & tx_shift_reg[FRAME_W-1];
  assign start        = start_reg;
  assign wr_ptr       = wr_ptr_reg;
  assign result_ready = result_ready_reg;
  assign frame_err    = frame_err_reg;
  assign drop         = drop_reg;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: two instances (64b/3 regs/CPHA0 and
// 32b/2 regs/CPHA1) driven by an SPI master task and checked against a
// frame-level model of the register file, write pointer and result path.
module tb_spi_frame_slave;

  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic sclk0, cs_n0, mosi0, miso0, busy0, rv0, start0, rr0, fe0, drop0;
  logic [63:0]  rd0;
  logic [191:0] regs0;
  logic [1:0]   wp0;
  logic sclk1, cs_n1, mosi1, miso1, busy1, rv1, start1, rr1, fe1, drop1;
  logic [31:0]  rd1;
  logic [63:0]  regs1;
  logic [0:0]   wp1;

  spi_frame_slave #(.FRAME_W(64), .NUM_REGS(3), .CPHA(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0),
    .core_busy(busy0), .result_valid(rv0), .result_data(rd0), .regs_out(regs0),
    .start(start0), .wr_ptr(wp0), .result_ready(rr0), .frame_err(fe0), .drop(drop0));

  spi_frame_slave #(.FRAME_W(32), .NUM_REGS(2), .CPHA(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1),
    .core_busy(busy1), .result_valid(rv1), .result_data(rd1), .regs_out(regs1),
    .start(start1), .wr_ptr(wp1), .result_ready(rr1), .frame_err(fe1), .drop(drop1));

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model
  logic [63:0] m_regs [2][3];
  int          m_wp   [2];
  bit          m_rr   [2];
  logic [63:0] m_hold [2];
  bit          m_valid[2];

  function automatic int fw_of(input int d); return (d == 0) ? 64 : 32; endfunction
  function automatic int nr_of(input int d); return (d == 0) ? 3 : 2; endfunction
  function automatic logic get_miso(input int d);  return (d == 0) ? miso0 : miso1; endfunction
  function automatic logic get_start(input int d); return (d == 0) ? start0 : start1; endfunction
  function automatic logic get_fe(input int d);    return (d == 0) ? fe0 : fe1; endfunction
  function automatic logic get_drop(input int d);  return (d == 0) ? drop0 : drop1; endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sclk(input int d, input logic v); if (d == 0) sclk0 = v; else sclk1 = v; endtask
  task automatic set_cs(input int d, input logic v);   if (d == 0) cs_n0 = v; else cs_n1 = v; endtask
  task automatic set_mosi(input int d, input logic v); if (d == 0) mosi0 = v; else mosi1 = v; endtask
  task automatic set_busy(input int d, input logic v); if (d == 0) busy0 = v; else busy1 = v; endtask
  task automatic wait_clks(input int n); repeat (n) @(negedge clk); endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 3; r++) m_regs[d][r] = '0;
      m_wp[d] = 0; m_rr[d] = 1'b0; m_hold[d] = '0;
    end
  endtask

  // Per-cycle comparison of the quiescent outputs against the model.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (cs_n0) check("miso0_idle", miso0, 1'b0);
      if (cs_n1) check("miso1_idle", miso1, 1'b0);
      if (rst && m_valid[0]) begin
        check("regs0", regs0, {m_regs[0][2], m_regs[0][1], m_regs[0][0]});
        check("wr_ptr0", wp0, m_wp[0]);
        check("result_ready0", rr0, m_rr[0]);
      end
      if (rst && m_valid[1]) begin
        check("regs1", regs1, {m_regs[1][1][31:0], m_regs[1][0][31:0]});
        check("wr_ptr1", wp1, m_wp[1]);
        check("result_ready1", rr1, m_rr[1]);
      end
    end
  end

  // SPI master: MSB first, returns the MISO bits in the same layout as data.
  task automatic spi_frame(input int d, input int nbits, input logic [127:0] data,
                           input bit raise, output logic [127:0] rx);
    rx = '0;
    set_cs(d, 1'b0);
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (d == 0) begin
        set_mosi(d, data[nbits-1-i]);
        wait_clks(HALF);
        set_sclk(d, 1'b1);
        rx[nbits-1-i] = get_miso(d);
        wait_clks(HALF);
        set_sclk(d, 1'b0);
      end else begin
        set_mosi(d, data[nbits-1-i]);
        set_sclk(d, 1'b1);
        wait_clks(HALF);
        set_sclk(d, 1'b0);
        rx[nbits-1-i] = get_miso(d);
        wait_clks(HALF);
      end
    end
    if (d == 0) wait_clks(HALF);
    if (raise) set_cs(d, 1'b1);
  endtask

  // Watch the pulses for a fixed window after cs_n rises.
  task automatic settle(input int d, output int ns, output int ne, output int nd, output int fs);
    ns = 0; ne = 0; nd = 0; fs = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (get_start(d)) begin ns++; if (fs < 0) fs = k; end
      if (get_fe(d))   ne++;
      if (get_drop(d)) nd++;
    end
  endtask

  task automatic do_frame(input int d, input int nbits, input logic [127:0] data,
                          input bit busy, output logic [127:0] rx);
    logic [127:0] exp_rx;
    logic [63:0]  word;
    int ns, ne, nd, fs, fw, e_s, e_e, e_d;
    bit rb;
    fw = fw_of(d);
    m_valid[d] = 1'b0;
    set_busy(d, busy);
    rb = m_rr[d];
    word = rb ? m_hold[d] : 64'h0;
    exp_rx = '0;
    for (int i = 0; i < nbits; i++) exp_rx[nbits-1-i] = (i < fw) ? word[fw-1-i] : 1'b0;
    spi_frame(d, nbits, data, 1'b1, rx);
    settle(d, ns, ne, nd, fs);
    set_busy(d, 1'b0);
    e_s = 0; e_e = 0; e_d = 0;
    if (nbits != fw) e_e = 1;
    else if (rb) m_rr[d] = 1'b0;
    else if (busy) e_d = 1;
    else begin
      m_regs[d][m_wp[d]] = data[63:0];
      if (m_wp[d] == nr_of(d) - 1) begin m_wp[d] = 0; e_s = 1; end
      else m_wp[d]++;
    end
    check("frame_err_pulses", ne, e_e);
    check("drop_pulses", nd, e_d);
    check("start_pulses", ns, e_s);
    if (e_s != 0) check("start_latency", fs, 4);
    check("miso_bits", rx, exp_rx);
    m_valid[d] = 1'b1;
    $display("frame dut=%0d bits=%0d busy=%0d readback=%0d data=%0h miso=%0h wr_ptr=%0d",
             d, nbits, busy, rb, data, rx, m_wp[d]);
  endtask

  task automatic pulse_result(input int d, input logic [63:0] v);
    m_valid[d] = 1'b0;
    @(negedge clk);
    if (d == 0) begin rv0 = 1'b1; rd0 = v; end else begin rv1 = 1'b1; rd1 = v[31:0]; end
    @(negedge clk);
    if (d == 0) rv0 = 1'b0; else rv1 = 1'b0;
    m_hold[d] = (d == 0) ? v : {32'h0, v[31:0]};
    m_rr[d] = 1'b1;
    wait_clks(2);
    m_valid[d] = 1'b1;
    $display("result dut=%0d value=%0h", d, v);
  endtask

  task automatic random_frames(input int d, input int n);
    logic [127:0] data, mask, one, rx;
    int nbits, fw, r;
    bit busy;
    fw = fw_of(d);
    one = 128'h1;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 2) == 0) pulse_result(d, {$urandom, $urandom});
      r = $urandom_range(0, 9);
      if (r == 0)      nbits = $urandom_range(8, fw - 1);
      else if (r == 1) nbits = $urandom_range(fw + 1, fw + 3);
      else             nbits = fw;
      busy = ($urandom_range(0, 3) == 0);
      mask = (one << nbits) - one;
      data = {$urandom, $urandom, $urandom, $urandom} & mask;
      do_frame(d, nbits, data, busy, rx);
    end
  endtask

  initial begin
    logic [127:0] rx;
    int ns, ne, nd, fs;
    rst = 1'b0;
    sclk0 = 0; cs_n0 = 1; mosi0 = 0; busy0 = 0; rv0 = 0; rd0 = '0;
    sclk1 = 0; cs_n1 = 1; mosi1 = 0; busy1 = 0; rv1 = 0; rd1 = '0;
    m_valid[0] = 0; m_valid[1] = 0;
    model_reset();
    wait_clks(5);
    check("reset_regs0", regs0, 192'h0);
    check("reset_wr_ptr0", wp0, 2'd0);
    check("reset_outs0", {miso0, start0, rr0, fe0, drop0}, 5'b0);
    check("reset_outs1", {miso1, start1, rr1, fe1, drop1, regs1}, 69'h0);
    rst = 1'b1;
    wait_clks(5);
    m_valid[0] = 1; m_valid[1] = 1;

    // Three-register command
    do_frame(0, 64, 128'h752878397493CB70, 1'b0, rx);
    check("c1_wr_ptr_a", wp0, 2'd1);
    do_frame(0, 64, 128'h1122334455667788, 1'b0, rx);
    check("c1_wr_ptr_b", wp0, 2'd2);
    do_frame(0, 64, 128'h0, 1'b0, rx);
    check("c1_wr_ptr_c", wp0, 2'd0);
    check("c1_regs", regs0, 192'h0000000000000000_1122334455667788_752878397493CB70);

    // Result readback
    pulse_result(0, 64'hB5219EE81AA7499D);
    check("c2_ready_set", rr0, 1'b1);
    do_frame(0, 64, {64'h0, 64'hFFFFFFFFFFFFFFFF}, 1'b0, rx);
    check("c2_miso", rx[63:0], 64'hB5219EE81AA7499D);
    check("c2_ready_clr", rr0, 1'b0);
    check("c2_regs", regs0, 192'h0000000000000000_1122334455667788_752878397493CB70);

    // Bad frame lengths, then a good one
    do_frame(0, 40, 128'h12_3456_789A, 1'b0, rx);
    do_frame(0, 65, 128'h1_FEDC_BA98_7654_3210, 1'b0, rx);
    do_frame(0, 64, 128'hAABB09182736CCDD, 1'b0, rx);
    check("c3_reg0", regs0[63:0], 64'hAABB09182736CCDD);
    check("c3_wr_ptr", wp0, 2'd1);

    // Busy lockout, then rewrite
    for (int i = 0; i < 3; i++) do_frame(0, 64, {$urandom, $urandom}, 1'b1, rx);
    for (int i = 0; i < 3; i++) do_frame(0, 64, {$urandom, $urandom}, 1'b0, rx);

    random_frames(0, 12);

    // CPHA=1 instance
    do_frame(1, 32, 128'h12345678, 1'b0, rx);
    do_frame(1, 32, 128'h9ABCDEF0, 1'b0, rx);
    check("c5_regs", regs1, 64'h9ABCDEF0_12345678);
    pulse_result(1, 64'h0F0F0F0F);
    do_frame(1, 32, 128'h0, 1'b0, rx);
    check("c5_miso", rx[31:0], 32'h0F0F0F0F);
    random_frames(1, 14);

    // cs_n glitch between clock edges
    @(negedge clk); #1 cs_n0 = 1'b0; #2 cs_n0 = 1'b1;
    settle(0, ns, ne, nd, fs);
    check("glitch_pulses", ns + ne + nd, 0);

    // Reset in the middle of a write frame
    spi_frame(0, 30, 128'h2AAA_5555, 1'b0, rx);
    m_valid[0] = 0; m_valid[1] = 0;
    rst = 1'b0;
    wait_clks(3);
    check("c6_in_reset", {regs0, wp0, miso0, start0, rr0, fe0, drop0}, 199'h0);
    @(negedge clk); rst = 1'b1;
    model_reset();
    wait_clks(10);
    check("c6_after_release", {regs0, wp0, miso0, start0, rr0, fe0, drop0}, 199'h0);
    set_cs(0, 1'b1);
    settle(0, ns, ne, nd, fs);
    check("c6_no_commit", ns + ne + nd, 0);
    m_valid[0] = 1; m_valid[1] = 1;
    do_frame(0, 64, 128'hC0FFEE0123456789, 1'b0, rx);
    check("c6_reg0", regs0, {128'h0, 64'hC0FFEE0123456789});

    wait_clks(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
Parametrised SPI slave front end for the cipher cores. It replaces the fixed three-frame, 64-bit SPI register file with one that has configurable frame width, register count and clock phase. It adds framing-error detection, busy lockout and a dedicated result readback path. It sits between the external SPI pins and the DES/cipher datapath: it loads key/data/control registers, issues a start pulse and returns the core's result on MISO.

Parameters:
FRAME_W, 64, bits per SPI frame (MSB first), >= 8
NUM_REGS, 3, frames per command (reg 0 = key, reg 1 = data, ..., last reg = control), >= 1
CPHA, 0, 0: MOSI sampled on rising sclk, MISO changes on falling; 1: MISO changes on rising, sampled on falling (CPOL fixed 0)
SYNC_STAGES, 2, synchroniser depth for sclk/cs_n/mosi, >= 2

Ports:
clk  in  1  system clock; must be >= 8x sclk frequency
rst  in  1  asynchronous, active-low reset
sclk  in  1  SPI clock, asynchronous to clk
cs_n  in  1  SPI chip select, active low
mosi  in  1  SPI data in
miso  out  1  SPI data out; 0 whenever cs_n is high
core_busy  in  1  core is processing; register writes are dropped while high
result_valid  in  1  one-clk pulse; result_data is captured
result_data  in  FRAME_W  core output word
regs_out  out  NUM_REGS*FRAME_W  register file, reg i at bits [i*FRAME_W +: FRAME_W]
start  out  1  one-clk pulse after the last register of a command is committed
wr_ptr  out  clog2(NUM_REGS) (min 1)  index of the next register to write
result_ready  out  1  held result is awaiting readback
frame_err  out  1  one-clk pulse on a bad frame length
drop  out  1  one-clk pulse when a write is discarded due to core_busy

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers, the hold register and the shift registers clear to 0.
  - wr_ptr=0. State = IDLE.
  - miso, start, result_ready, frame_err and drop are all 0.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected from the last two synchronised samples. All logic is in the clk domain.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on a synced cs_n falling edge. On entry: bit_cnt=0; tx_shift loaded with the hold register if result_ready=1, else all zeros. miso drives tx_shift MSB immediately.
  - SHIFT: each sample edge shifts the synced mosi into rx_shift LSB and increments bit_cnt. bit_cnt saturates at FRAME_W+1. Each change edge shifts tx_shift left.
  - SHIFT -> COMMIT on a synced cs_n rising edge.
  - COMMIT -> IDLE after exactly 1 clk.
- COMMIT rules:
  - bit_cnt != FRAME_W (short or long frame): frame_err pulse. Frame discarded; wr_ptr and result_ready unchanged.
  - Readback frame (result_ready was 1 at frame start), exact length: rx data discarded, result_ready cleared, wr_ptr unchanged.
  - Write frame, exact length, core_busy=1 in the COMMIT cycle: drop pulse; register and wr_ptr unchanged.
  - Write frame, exact length, core_busy=0: regs[wr_ptr] <= rx_shift.
    - If wr_ptr == NUM_REGS-1: wr_ptr wraps to 0 and start pulses in the next clk.
    - Otherwise wr_ptr increments.
- Result capture: result_valid stores result_data into the hold register and sets result_ready in the next clk.
  - If result_valid coincides with the end of a readback frame, result_ready stays set and hold takes the new value.
  - result_valid during SHIFT updates hold but not tx_shift.
- Latency: cs_n rising pin edge to COMMIT is SYNC_STAGES+1 clks. The start pulse follows COMMIT by 1 clk.
- Reset mid-frame aborts with no commit. After release, if cs_n is low, the block waits for cs_n to go high before accepting a new frame.
- A cs_n glitch shorter than one synchronised sample is ignored. No tri-state output.

Test Plan:
1. FRAME_W=64, NUM_REGS=3, CPHA=0. Write 752878397493CB70, 1122334455667788, 0000000000000000 -> reg0/reg1/reg2 hold those values, wr_ptr sequence 1, 2, 0, a single start pulse after the third frame, no frame_err.
2. After case 1, pulse result_valid with B5219EE81AA7499D, then run a 64-bit readback frame with mosi=1 -> miso returns B5219EE81AA7499D, result_ready 1 -> 0, regs unchanged, wr_ptr=0.
3. Send a 40-bit frame, then a 65-bit frame -> frame_err pulses twice, wr_ptr and registers unchanged. A following 64-bit frame AABB09182736CCDD lands in reg0.
4. Hold core_busy=1 and write three frames -> three drop pulses, no start, registers keep their prior values. Release busy and rewrite -> start fires.
5. CPHA=1, FRAME_W=32, NUM_REGS=2. Write 12345678, then 9ABCDEF0 -> regs correct, start fires. Readback after a result_valid of 0F0F0F0F -> miso yields 0F0F0F0F.
6. Assert rst low at bit 30 of a write frame, release with cs_n still low -> no commit, all outputs 0. The next full frame (after cs_n goes high then low) writes reg0.
